// File: rtl/axil_dma_arb_if.sv
// AXI-lite bus bundle for the arbiter's shared downstream DMA port.
//   master modport : drives AW/W/AR channels and B/R ready
//   slave  modport : drives AW/W/AR ready and B/R responses
interface axil_intf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_dma_arb.sv
// Round-robin arbiter merging NUM_CH AXI-lite DMA requesters onto one
// downstream AXI-lite master. Writes and reads are arbitrated by independent
// FSMs, each allowing a single outstanding transaction.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*     : per-channel write ports, channel k at [k*W +: W]
//   s_ar*/s_r*          : per-channel read ports, channel k at [k*W +: W]
//   m_dma_axil          : shared downstream AXI-lite master
//   o_wr_gnt/o_rd_gnt   : one-hot current grant, 0 while idle
module axil_dma_arb #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_CH-1:0]              s_awvalid,
  output logic [NUM_CH-1:0]              s_awready,
  input  logic [NUM_CH*ADDR_W-1:0]       s_awaddr,
  input  logic [NUM_CH*3-1:0]            s_awprot,
  input  logic [NUM_CH-1:0]              s_wvalid,
  output logic [NUM_CH-1:0]              s_wready,
  input  logic [NUM_CH*DATA_W-1:0]       s_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   s_wstrb,
  output logic [NUM_CH-1:0]              s_bvalid,
  input  logic [NUM_CH-1:0]              s_bready,
  output logic [NUM_CH*2-1:0]            s_bresp,
  input  logic [NUM_CH-1:0]              s_arvalid,
  output logic [NUM_CH-1:0]              s_arready,
  input  logic [NUM_CH*ADDR_W-1:0]       s_araddr,
  input  logic [NUM_CH*3-1:0]            s_arprot,
  output logic [NUM_CH-1:0]              s_rvalid,
  input  logic [NUM_CH-1:0]              s_rready,
  output logic [NUM_CH*DATA_W-1:0]       s_rdata,
  output logic [NUM_CH*2-1:0]            s_rresp,
  axil_intf.master                       m_dma_axil,
  output logic [NUM_CH-1:0]              o_wr_gnt,
  output logic [NUM_CH-1:0]              o_rd_gnt
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  // Per-channel views of the flat packed ports
  logic [NUM_CH-1:0][ADDR_W-1:0] awaddr_a, araddr_a;
  logic [NUM_CH-1:0][2:0]        awprot_a, arprot_a;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata_a, rdata_a;
  logic [NUM_CH-1:0][STRB_W-1:0] wstrb_a;
  logic [NUM_CH-1:0][1:0]        bresp_a, rresp_a;

  assign awaddr_a = s_awaddr;
  assign awprot_a = s_awprot;
  assign wdata_a  = s_wdata;
  assign wstrb_a  = s_wstrb;
  assign araddr_a = s_araddr;
  assign arprot_a = s_arprot;
  assign s_bresp  = bresp_a;
  assign s_rdata  = rdata_a;
  assign s_rresp  = rresp_a;

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [IDX_W-1:0] w_gnt_q, w_gnt_d, w_last_q, w_last_d;
  logic [IDX_W-1:0] r_gnt_q, r_gnt_d, r_last_q, r_last_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

  // First requester strictly after 'last', wrapping at NUM_CH-1
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [IDX_W-1:0]  last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = (32'(last) + i) % NUM_CH;
      if (!found && req[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // State registers for both FSMs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      w_gnt_q   <= '0;
      r_gnt_q   <= '0;
      w_last_q  <= LAST_RST;
      r_last_q  <= LAST_RST;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      w_gnt_q   <= w_gnt_d;
      r_gnt_q   <= r_gnt_d;
      w_last_q  <= w_last_d;
      r_last_q  <= r_last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Write FSM: AW and W may complete in either order; done flags stop re-issue
  always_comb begin
    w_state_d          = w_state_q;
    w_gnt_d            = w_gnt_q;
    w_last_d           = w_last_q;
    aw_done_d          = aw_done_q;
    w_done_d           = w_done_q;
    s_awready          = '0;
    s_wready           = '0;
    s_bvalid           = '0;
    bresp_a            = '0;
    m_dma_axil.awvalid = 1'b0;
    m_dma_axil.awaddr  = '0;
    m_dma_axil.awprot  = '0;
    m_dma_axil.wvalid  = 1'b0;
    m_dma_axil.wdata   = '0;
    m_dma_axil.wstrb   = '0;
    m_dma_axil.bready  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (|s_awvalid) begin
          w_gnt_d   = rr_pick(s_awvalid, w_last_q);
          w_last_d  = w_gnt_d;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_dma_axil.awvalid = s_awvalid[w_gnt_q] & ~aw_done_q;
        m_dma_axil.awaddr  = awaddr_a[w_gnt_q];
        m_dma_axil.awprot  = awprot_a[w_gnt_q];
        m_dma_axil.wvalid  = s_wvalid[w_gnt_q] & ~w_done_q;
        m_dma_axil.wdata   = wdata_a[w_gnt_q];
        m_dma_axil.wstrb   = wstrb_a[w_gnt_q];
        s_awready[w_gnt_q] = m_dma_axil.awready & ~aw_done_q;
        s_wready[w_gnt_q]  = m_dma_axil.wready & ~w_done_q;
        aw_done_d = aw_done_q | (s_awvalid[w_gnt_q] & m_dma_axil.awready);
        w_done_d  = w_done_q | (s_wvalid[w_gnt_q] & m_dma_axil.wready);
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: begin
        s_bvalid[w_gnt_q] = m_dma_axil.bvalid;
        bresp_a[w_gnt_q]  = m_dma_axil.bresp;
        m_dma_axil.bready = s_bready[w_gnt_q];
        if (m_dma_axil.bvalid && s_bready[w_gnt_q]) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: single AR beat, then route R back to the granted channel
  always_comb begin
    r_state_d          = r_state_q;
    r_gnt_d            = r_gnt_q;
    r_last_d           = r_last_q;
    s_arready          = '0;
    s_rvalid           = '0;
    rdata_a            = '0;
    rresp_a            = '0;
    m_dma_axil.arvalid = 1'b0;
    m_dma_axil.araddr  = '0;
    m_dma_axil.arprot  = '0;
    m_dma_axil.rready  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (|s_arvalid) begin
          r_gnt_d   = rr_pick(s_arvalid, r_last_q);
          r_last_d  = r_gnt_d;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_dma_axil.arvalid = s_arvalid[r_gnt_q];
        m_dma_axil.araddr  = araddr_a[r_gnt_q];
        m_dma_axil.arprot  = arprot_a[r_gnt_q];
        s_arready[r_gnt_q] = m_dma_axil.arready;
        if (s_arvalid[r_gnt_q] && m_dma_axil.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_rvalid[r_gnt_q] = m_dma_axil.rvalid;
        rdata_a[r_gnt_q]  = m_dma_axil.rdata;
        rresp_a[r_gnt_q]  = m_dma_axil.rresp;
        m_dma_axil.rready = s_rready[r_gnt_q];
        if (m_dma_axil.rvalid && s_rready[r_gnt_q]) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Grant outputs decoded from registered state only
  always_comb begin
    o_wr_gnt = '0;
    o_rd_gnt = '0;
    if (w_state_q != W_IDLE) o_wr_gnt[w_gnt_q] = 1'b1;
    if (r_state_q != R_IDLE) o_rd_gnt[r_gnt_q] = 1'b1;
  end

endmodule

// File: tb/tb_axil_dma_arb.sv
// Directed bench for axil_dma_arb: a 4-channel instance and a 1-channel,
// 24-bit-address instance, with the bench acting as masters and downstream slave.
module tb_axil_dma_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 4-channel instance
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready, o_wr_gnt, o_rd_gnt;
  logic [N*AW-1:0]   s_awaddr, s_araddr;
  logic [N*3-1:0]    s_awprot, s_arprot;
  logic [N*DW-1:0]   s_wdata, s_rdata;
  logic [N*DW/8-1:0] s_wstrb;
  logic [N*2-1:0]    s_bresp, s_rresp;
  axil_intf #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  axil_dma_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_dma_axil(m_if), .o_wr_gnt(o_wr_gnt), .o_rd_gnt(o_rd_gnt)
  );

  // 1-channel instance with 24-bit addresses
  logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, o1_wr_gnt, o1_rd_gnt;
  logic [23:0] s1_awaddr, s1_araddr;
  logic [2:0]  s1_awprot, s1_arprot;
  logic [31:0] s1_wdata, s1_rdata;
  logic [3:0]  s1_wstrb;
  logic [1:0]  s1_bresp, s1_rresp;
  axil_intf #(.ADDR_W(24), .DATA_W(32)) m1_if ();

  axil_dma_arb #(.NUM_CH(1), .ADDR_W(24), .DATA_W(32)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .s_awvalid(s1_awvalid), .s_awready(s1_awready), .s_awaddr(s1_awaddr), .s_awprot(s1_awprot),
    .s_wvalid(s1_wvalid), .s_wready(s1_wready), .s_wdata(s1_wdata), .s_wstrb(s1_wstrb),
    .s_bvalid(s1_bvalid), .s_bready(s1_bready), .s_bresp(s1_bresp),
    .s_arvalid(s1_arvalid), .s_arready(s1_arready), .s_araddr(s1_araddr), .s_arprot(s1_arprot),
    .s_rvalid(s1_rvalid), .s_rready(s1_rready), .s_rdata(s1_rdata), .s_rresp(s1_rresp),
    .m_dma_axil(m1_if), .o_wr_gnt(o1_wr_gnt), .o_rd_gnt(o1_rd_gnt)
  );

  task automatic idle_inputs();
    s_awvalid = '0; s_awaddr = '0; s_awprot = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = '0; s_arvalid = '0; s_araddr = '0; s_arprot = '0; s_rready = '0;
    s1_awvalid = 1'b0; s1_awaddr = '0; s1_awprot = '0; s1_wvalid = 1'b0; s1_wdata = '0;
    s1_wstrb = '0; s1_bready = 1'b0; s1_arvalid = 1'b0; s1_araddr = '0; s1_arprot = '0;
    s1_rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = '0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0;
    m1_if.awready = 1'b0; m1_if.wready = 1'b0; m1_if.bvalid = 1'b0; m1_if.bresp = '0;
    m1_if.arready = 1'b0; m1_if.rvalid = 1'b0; m1_if.rdata = '0; m1_if.rresp = '0;
  endtask

  task automatic test_reset();
    s_awvalid = '1; s_wvalid = '1; s_arvalid = '1; s1_arvalid = 1'b1;
    m_if.awready = 1'b1; m_if.bvalid = 1'b1; m_if.rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (o_wr_gnt !== 4'b0000) begin tests_failed++; $display("FAIL rst_wr_gnt got=%b exp=0000", o_wr_gnt); end
    tests_run++; if (o_rd_gnt !== 4'b0000) begin tests_failed++; $display("FAIL rst_rd_gnt got=%b exp=0000", o_rd_gnt); end
    tests_run++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b0)
      begin tests_failed++; $display("FAIL rst_m_handshake got=%b exp=00000", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}); end
    tests_run++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 20'b0)
      begin tests_failed++; $display("FAIL rst_s_handshake got=%h exp=0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}); end
    tests_run++; if (o1_rd_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_ch1_rd_gnt got=%b exp=0", o1_rd_gnt); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    s_awvalid = 4'b0100; s_awaddr[2*AW +: AW] = 32'h0000_1000; s_awprot[6 +: 3] = 3'b010;
    s_wvalid  = 4'b0100; s_wdata[2*DW +: DW] = 32'hDEAD_BEEF; s_wstrb[8 +: 4] = 4'hF;
    s_bready  = 4'b0100;
    #1;
    tests_run++; if (m_if.awvalid !== 1'b0) begin tests_failed++; $display("FAIL sw_aw_early got=%b exp=0", m_if.awvalid); end
    @(negedge clk); #1;
    tests_run++; if (m_if.awvalid !== 1'b1) begin tests_failed++; $display("FAIL sw_awvalid got=%b exp=1", m_if.awvalid); end
    tests_run++; if (m_if.awaddr !== 32'h0000_1000) begin tests_failed++; $display("FAIL sw_awaddr got=%h exp=00001000", m_if.awaddr); end
    tests_run++; if (m_if.awprot !== 3'b010) begin tests_failed++; $display("FAIL sw_awprot got=%b exp=010", m_if.awprot); end
    tests_run++; if (m_if.wdata !== 32'hDEAD_BEEF || m_if.wvalid !== 1'b1)
      begin tests_failed++; $display("FAIL sw_wdata got=%h/%b exp=deadbeef/1", m_if.wdata, m_if.wvalid); end
    tests_run++; if (s_awready !== 4'b0100 || s_wready !== 4'b0100)
      begin tests_failed++; $display("FAIL sw_s_ready got=%b/%b exp=0100/0100", s_awready, s_wready); end
    tests_run++; if (o_wr_gnt !== 4'b0100) begin tests_failed++; $display("FAIL sw_gnt_addr got=%b exp=0100", o_wr_gnt); end
    @(negedge clk);
    s_awvalid = '0; s_wvalid = '0; m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    #1;
    tests_run++; if (m_if.awvalid !== 1'b0 || m_if.awaddr !== '0)
      begin tests_failed++; $display("FAIL sw_aw_after got=%b/%h exp=0/0", m_if.awvalid, m_if.awaddr); end
    tests_run++; if (s_bvalid !== 4'b0100 || s_bresp !== 8'h00)
      begin tests_failed++; $display("FAIL sw_bvalid got=%b/%h exp=0100/00", s_bvalid, s_bresp); end
    tests_run++; if (m_if.bready !== 1'b1 || o_wr_gnt !== 4'b0100)
      begin tests_failed++; $display("FAIL sw_resp_gnt got=%b/%b exp=1/0100", m_if.bready, o_wr_gnt); end
    @(negedge clk);
    m_if.bvalid = 1'b0;
    #1;
    tests_run++; if (o_wr_gnt !== 4'b0000) begin tests_failed++; $display("FAIL sw_gnt_idle got=%b exp=0000", o_wr_gnt); end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [AW-1:0] cap_addr;
    int            ec;
    m_if.arready = 1'b1; s_rready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      s_araddr[k*AW +: AW] = 32'hA000_0000 + 32'(k);
      s_arprot[k*3 +: 3]   = 3'(k + 1);
    end
    s_arvalid = 4'hF;
    for (int t = 0; t < 5; t++) begin
      ec = t % 4;
      @(negedge clk); #1;
      tests_run++; if (o_rd_gnt !== 4'(1 << ec)) begin tests_failed++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", t, o_rd_gnt, 4'(1 << ec)); end
      tests_run++; if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'hA000_0000 + 32'(ec) || m_if.arprot !== 3'(ec + 1))
        begin tests_failed++; $display("FAIL rr_ar[%0d] got=%b/%h/%b exp=1/%h/%b", t, m_if.arvalid, m_if.araddr, m_if.arprot, 32'hA000_0000 + 32'(ec), 3'(ec + 1)); end
      tests_run++; if (s_arready !== 4'(1 << ec)) begin tests_failed++; $display("FAIL rr_arready[%0d] got=%b exp=%b", t, s_arready, 4'(1 << ec)); end
      cap_addr = m_if.araddr;
      @(negedge clk);
      m_if.rvalid = 1'b1; m_if.rdata = cap_addr; m_if.rresp = 2'b00;
      #1;
      tests_run++; if (s_rvalid !== 4'(1 << ec)) begin tests_failed++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", t, s_rvalid, 4'(1 << ec)); end
      tests_run++; if (s_rdata[ec*DW +: DW] !== 32'hA000_0000 + 32'(ec))
        begin tests_failed++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", t, s_rdata[ec*DW +: DW], 32'hA000_0000 + 32'(ec)); end
      @(negedge clk);
      m_if.rvalid = 1'b0;
      #1;
      tests_run++; if (o_rd_gnt !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle[%0d] got=%b exp=0000", t, o_rd_gnt); end
    end
    idle_inputs();
  endtask

  task automatic test_split_aw_w();
    int n_aw = 0, n_saw = 0, n_sw = 0;
    m_if.awready = 1'b1; m_if.wready = 1'b0;
    s_awvalid = 4'b0010; s_awaddr[AW +: AW] = 32'h0000_2000;
    s_wvalid  = 4'b0010; s_wdata[DW +: DW] = 32'h1234_5678; s_wstrb[4 +: 4] = 4'h3;
    s_bready  = 4'b0010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) m_if.wready = 1'b1;
      #1;
      n_aw  += int'(m_if.awvalid && m_if.awready);
      n_saw += int'(s_awready[1]);
      n_sw  += int'(s_wready[1]);
      if (c == 1) begin
        tests_run++; if (s_awready !== 4'b0010 || s_wready !== 4'b0000 || m_if.wvalid !== 1'b1)
          begin tests_failed++; $display("FAIL split_c1 got=%b/%b/%b exp=0010/0000/1", s_awready, s_wready, m_if.wvalid); end
      end
      if (c == 3) begin
        tests_run++; if (m_if.awvalid !== 1'b0 || o_wr_gnt !== 4'b0010)
          begin tests_failed++; $display("FAIL split_wait got=%b/%b exp=0/0010", m_if.awvalid, o_wr_gnt); end
      end
      if (c == 5) begin
        tests_run++; if (s_wready !== 4'b0010 || m_if.wdata !== 32'h1234_5678 || m_if.wstrb !== 4'h3)
          begin tests_failed++; $display("FAIL split_w got=%b/%h/%h exp=0010/12345678/3", s_wready, m_if.wdata, m_if.wstrb); end
      end
    end
    @(negedge clk);
    s_awvalid = '0; s_wvalid = '0; m_if.wready = 1'b0; m_if.bvalid = 1'b1; m_if.bresp = 2'b10;
    #1;
    tests_run++; if (n_aw !== 1) begin tests_failed++; $display("FAIL split_m_aw_count got=%0d exp=1", n_aw); end
    tests_run++; if (n_saw !== 1 || n_sw !== 1) begin tests_failed++; $display("FAIL split_s_pulses got=%0d/%0d exp=1/1", n_saw, n_sw); end
    tests_run++; if (s_bvalid !== 4'b0010 || s_bresp !== 8'h08)
      begin tests_failed++; $display("FAIL split_slverr got=%b/%h exp=0010/08", s_bvalid, s_bresp); end
    @(negedge clk);
    m_if.bvalid = 1'b0;
    #1;
    tests_run++; if (o_wr_gnt !== 4'b0000) begin tests_failed++; $display("FAIL split_idle got=%b exp=0000", o_wr_gnt); end
    idle_inputs();
  endtask

  task automatic test_concurrency();
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    s_awvalid = 4'b0010; s_awaddr[AW +: AW] = 32'h0000_3000;
    s_wvalid  = 4'b0010; s_wdata[DW +: DW] = 32'h55AA_55AA; s_bready = 4'b0010;
    s_arvalid = 4'b1000; s_araddr[3*AW +: AW] = 32'h0000_4000; s_rready = 4'b1000;
    @(negedge clk); #1;
    tests_run++; if (o_wr_gnt !== 4'b0010 || o_rd_gnt !== 4'b1000)
      begin tests_failed++; $display("FAIL conc_gnt got=%b/%b exp=0010/1000", o_wr_gnt, o_rd_gnt); end
    tests_run++; if (m_if.awaddr !== 32'h0000_3000 || m_if.araddr !== 32'h0000_4000)
      begin tests_failed++; $display("FAIL conc_addr got=%h/%h exp=00003000/00004000", m_if.awaddr, m_if.araddr); end
    @(negedge clk);
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
    m_if.rvalid = 1'b1; m_if.rdata = 32'hCAFE_F00D; m_if.rresp = 2'b01;
    #1;
    tests_run++; if (s_bvalid !== 4'b0010 || s_rvalid !== 4'b1000)
      begin tests_failed++; $display("FAIL conc_resp got=%b/%b exp=0010/1000", s_bvalid, s_rvalid); end
    tests_run++; if (s_rdata[3*DW +: DW] !== 32'hCAFE_F00D || s_rdata[3*DW-1:0] !== '0 || s_rresp !== 8'h40)
      begin tests_failed++; $display("FAIL conc_rdata got=%h/%h exp=cafef00d/40", s_rdata[3*DW +: DW], s_rresp); end
    @(negedge clk);
    m_if.bvalid = 1'b0; m_if.rvalid = 1'b0;
    #1;
    tests_run++; if (o_wr_gnt !== 4'b0000 || o_rd_gnt !== 4'b0000)
      begin tests_failed++; $display("FAIL conc_idle got=%b/%b exp=0000/0000", o_wr_gnt, o_rd_gnt); end
    idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    s_awvalid = 4'b0001; s_awaddr[0 +: AW] = 32'h0000_5000; s_wvalid = 4'b0001;
    @(negedge clk); #1;
    tests_run++; if (o_wr_gnt !== 4'b0001) begin tests_failed++; $display("FAIL rir_gnt0 got=%b exp=0001", o_wr_gnt); end
    @(negedge clk);
    s_awvalid = '0; s_wvalid = '0; m_if.bvalid = 1'b1; m_if.bresp = 2'b11;
    #1;
    tests_run++; if (s_bvalid !== 4'b0001 || s_bresp !== 8'h03)
      begin tests_failed++; $display("FAIL rir_pending got=%b/%h exp=0001/03", s_bvalid, s_bresp); end
    @(negedge clk);
    rst = 1'b1;
    s_awvalid = 4'b1001; s_wvalid = 4'b1001; s_awaddr[3*AW +: AW] = 32'h0000_6000;
    #1;
    tests_run++; if (s_bvalid !== 4'b0000 || s_bresp !== 8'h00 || o_wr_gnt !== 4'b0000)
      begin tests_failed++; $display("FAIL rir_rst_s got=%b/%h/%b exp=0000/00/0000", s_bvalid, s_bresp, o_wr_gnt); end
    tests_run++; if (m_if.bready !== 1'b0 || m_if.awvalid !== 1'b0 || s_awready !== 4'b0000)
      begin tests_failed++; $display("FAIL rir_rst_m got=%b/%b/%b exp=0/0/0000", m_if.bready, m_if.awvalid, s_awready); end
    @(negedge clk);
    rst = 1'b0; m_if.bvalid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (o_wr_gnt !== 4'b0001 || m_if.awaddr !== 32'h0000_5000)
      begin tests_failed++; $display("FAIL rir_ch0_first got=%b/%h exp=0001/00005000", o_wr_gnt, m_if.awaddr); end
    tests_run++; if (s_awready !== 4'b0001) begin tests_failed++; $display("FAIL rir_ch3_blocked got=%b exp=0001", s_awready); end
    @(negedge clk);
    s_awvalid = 4'b1000; s_wvalid = 4'b1000; m_if.bvalid = 1'b1; m_if.bresp = 2'b00; s_bready = 4'b0001;
    @(negedge clk);
    m_if.bvalid = 1'b0;
    @(negedge clk); #1;
    tests_run++; if (o_wr_gnt !== 4'b1000 || m_if.awaddr !== 32'h0000_6000)
      begin tests_failed++; $display("FAIL rir_ch3_waited got=%b/%h exp=1000/00006000", o_wr_gnt, m_if.awaddr); end
    @(negedge clk);
    s_awvalid = '0; s_wvalid = '0; m_if.bvalid = 1'b1; s_bready = 4'b1000;
    #1;
    tests_run++; if (s_bvalid !== 4'b1000) begin tests_failed++; $display("FAIL rir_ch3_b got=%b exp=1000", s_bvalid); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_single_channel_decerr();
    m1_if.arready = 1'b1; s1_arvalid = 1'b1; s1_araddr = 24'hABCDEF; s1_arprot = 3'b101; s1_rready = 1'b1;
    @(negedge clk); #1;
    tests_run++; if (o1_rd_gnt !== 1'b1 || s1_arready !== 1'b1)
      begin tests_failed++; $display("FAIL one_gnt got=%b/%b exp=1/1", o1_rd_gnt, s1_arready); end
    tests_run++; if (m1_if.araddr !== 24'hABCDEF || m1_if.arprot !== 3'b101)
      begin tests_failed++; $display("FAIL one_ar got=%h/%b exp=abcdef/101", m1_if.araddr, m1_if.arprot); end
    @(negedge clk);
    s1_arvalid = 1'b0; m1_if.rvalid = 1'b1; m1_if.rresp = 2'b11; m1_if.rdata = 32'h0BAD_0BAD;
    #1;
    tests_run++; if (s1_rvalid !== 1'b1 || s1_rresp !== 2'b11 || s1_rdata !== 32'h0BAD_0BAD)
      begin tests_failed++; $display("FAIL one_decerr got=%b/%b/%h exp=1/11/0bad0bad", s1_rvalid, s1_rresp, s1_rdata); end
    @(negedge clk);
    m1_if.rvalid = 1'b0;
    #1;
    tests_run++; if (o1_rd_gnt !== 1'b0) begin tests_failed++; $display("FAIL one_idle got=%b exp=0", o1_rd_gnt); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_split_aw_w();
    test_concurrency();
    test_reset_in_resp();
    test_single_channel_decerr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
